pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the program counter for the single-clock MIPS datapath; successor to the combinational pseudo-direct jump-address former.
- Each cycle it selects and registers the next PC from four sources: sequential, branch, pseudo-direct jump, or jump-register.
- Adds stall, a registered redirect pulse for pipeline flush, and a parametrised return-address stack (RAS) that checks JR-return targets.
- Sits between the IF stage instruction memory and the decode/branch-resolve logic.

Parameters:
ADDR_W, 32, PC/address width; must be at least JUMP_W+3.
JUMP_W, 26, width of the instruction jump field.
OFFS_W, 16, width of the branch immediate.
RAS_DEPTH, 4, return-address stack entries; power of two, at least 2.
RESET_PC, 32'h0000_0000, PC value loaded by reset; truncated to ADDR_W.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
stall  in  1  hold PC and RAS; suppress all updates
jump_valid  in  1  J/JAL accepted this cycle
jump_link  in  1  with jump_valid: JAL, push return address
jump_field  in  JUMP_W  instruction target field
branch_taken  in  1  conditional branch resolved taken
branch_offset  in  OFFS_W  signed word offset
jr_valid  in  1  JR/JALR accepted this cycle
jr_is_return  in  1  with jr_valid: JR $ra, pop RAS and compare
jr_target  in  ADDR_W  register-file target
pc  out  ADDR_W  current PC (register)
pc_plus4  out  ADDR_W  pc+4, combinational, mod 2^ADDR_W
redirect  out  1  registered; high one cycle after a non-sequential PC load
ras_mismatch  out  1  registered; high one cycle after a return whose popped value differs from jr_target
ras_underflow  out  1  registered; high one cycle after a return with an empty RAS
ras_empty  out  1  RAS count == 0 (combinational from count)

Behaviour:
- Reset: takes effect regardless of stall or any other input.
  - Clears pc to RESET_PC and the RAS count/pointer to 0.
  - Clears redirect, ras_mismatch and ras_underflow to 0; ras_empty is 1.
- Targets, all arithmetic mod 2^ADDR_W:
  - branch_tgt = pc_plus4 + (sign-extend(branch_offset) << 2).
  - jump_tgt = {pc_plus4[ADDR_W-1 : JUMP_W+2], jump_field, 2'b00}.
  - jr_tgt = jr_target, bits [1:0] forced to 0.
- Next-PC priority when stall=0: jr_valid > branch_taken > jump_valid > pc_plus4. pc updates at the clock edge, so latency is 1 cycle.
- redirect <= 1 when stall=0 and any of jr_valid, branch_taken or jump_valid is 1; otherwise 0.
- stall=1 holds pc and the RAS, and drives all three pulse outputs to 0. The sources are ignored, not queued.
- RAS is circular, RAS_DEPTH entries, with a top pointer and a count that saturates at RAS_DEPTH.
- Push: stall=0, jump_valid=1, jump_link=1, and no higher-priority source active.
  - Writes pc_plus4 at top+1 and advances the pointer.
  - When full, overwrites the oldest entry; count stays at RAS_DEPTH.
- Pop: stall=0, jr_valid=1, jr_is_return=1.
  - count>0: read the top entry, retreat the pointer, decrement count. ras_mismatch <= (entry != jr_tgt).
  - count==0: no pop; ras_underflow <= 1; ras_mismatch <= 0.
- A push is suppressed whenever jr_valid or branch_taken is also high, because the jump lost priority. Push and pop therefore never occur in the same cycle.
- The PC always follows jr_tgt. The RAS is a checker only and never steers the PC.
- Wrap: a PC at 2^ADDR_W-4 advances to 0 with no flag.

Test Plan:
- Reset then 3 free-running cycles -> pc = 0x0, 0x4, 0x8, 0xC; redirect = 0 throughout.
- pc=0x0040_0010, branch_taken with offset 0xFFFE -> next pc = 0x0040_000C; redirect = 1 for one cycle.
- pc=0x9000_0000, jump_valid+jump_link, jump_field=0x0000100 -> pc = 0x9000_0400 and RAS holds 0x9000_0004. Then jr_is_return with jr_target=0x9000_0004 -> pc = 0x9000_0004; ras_mismatch = 0; ras_empty = 1.
- Five JALs with RAS_DEPTH=4, then five returns using the correct targets -> the first four report mismatch=0. The fifth reports underflow=1, since the oldest entry was overwritten and count saturated at 4.
- jr_valid, branch_taken and jump_valid+jump_link in the same cycle -> pc = jr_target; no push; RAS count unchanged.
- stall=1 with branch_taken for 2 cycles, then stall=0 -> pc is held during the stall with redirect = 0. The branch only takes effect in the cycle where stall=0. Asserting reset during the stall loads RESET_PC immediately.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with next-PC selection,
// stall, registered redirect pulse and a return-address checker stack.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   stall                       hold PC and stack, suppress pulses
//   jump_valid/link/field       J/JAL pseudo-direct jump, JAL pushes
//   branch_taken/offset         taken branch, signed word offset
//   jr_valid/is_return/target   JR/JALR, returns pop and compare
//   pc, pc_plus4                current PC and its sequential successor
//   redirect                    one cycle after a non-sequential load
//   ras_mismatch/underflow      one cycle after a bad/empty return
//   ras_empty                   stack holds no entries
module pc_sequencer #(
  parameter int          ADDR_W    = 32,
  parameter int          JUMP_W    = 26,
  parameter int          OFFS_W    = 16,
  parameter int          RAS_DEPTH = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              jump_valid,
  input  logic              jump_link,
  input  logic [JUMP_W-1:0] jump_field,
  input  logic              branch_taken,
  input  logic [OFFS_W-1:0] branch_offset,
  input  logic              jr_valid,
  input  logic              jr_is_return,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              redirect,
  output logic              ras_mismatch,
  output logic              ras_underflow,
  output logic              ras_empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top;
  logic [PTR_W-1:0]  top_inc;
  logic [PTR_W-1:0]  top_dec;
  logic [CNT_W-1:0]  cnt;

  logic [ADDR_W-1:0] boff;
  logic [ADDR_W-1:0] branch_tgt;
  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] jr_tgt;
  logic [ADDR_W-1:0] pc_next;
  logic              any_redirect;
  logic              push;
  logic              pop_req;
  logic              pop;
  logic              top_differs;

  assign pc_plus4 = pc + ADDR_W'(4);

  assign boff = {{(ADDR_W-OFFS_W){branch_offset[OFFS_W-1]}},
                 branch_offset} << 2;

  assign branch_tgt = pc_plus4 + boff;

  assign jump_tgt = {pc_plus4[ADDR_W-1:JUMP_W+2],
                     jump_field, 2'b00};

  assign jr_tgt = jr_target & ~ADDR_W'(3);

  always_comb begin
    pc_next = pc_plus4;
    if (jr_valid)
      pc_next = jr_tgt;
    else if (branch_taken)
      pc_next = branch_tgt;
    else if (jump_valid)
      pc_next = jump_tgt;
  end

  assign any_redirect = jr_valid | branch_taken | jump_valid;

  assign ras_empty = (cnt == '0);
  assign top_inc   = top + 1'b1;
  assign top_dec   = top - 1'b1;

  // a JAL that lost priority to JR or a branch never links
  assign push = ~stall & jump_valid & jump_link
              & ~jr_valid & ~branch_taken;

  assign pop_req = ~stall & jr_valid & jr_is_return;
  assign pop     = pop_req & ~ras_empty;

  assign top_differs = (ras_mem[top] != jr_tgt);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RST_PC;
      top           <= '0;
      cnt           <= '0;
      redirect      <= 1'b0;
      ras_mismatch  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      redirect      <= ~stall & any_redirect;
      ras_mismatch  <= pop & top_differs;
      ras_underflow <= pop_req & ras_empty;
      if (!stall)
        pc <= pc_next;
      if (push) begin
        top <= top_inc;
        if (cnt != FULL)
          cnt <= cnt + 1'b1;
      end else if (pop) begin
        top <= top_dec;
        cnt <= cnt - 1'b1;
      end
    end
  end

  // when full, top+1 is the oldest slot, so it is simply overwritten
  always_ff @(posedge clk) begin
    if (!reset && push)
      ras_mem[top_inc] <= pc_plus4;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
// Linear steps, immediate assertions on every observed output.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        jump_valid;
  logic        jump_link;
  logic [25:0] jump_field;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jr_valid;
  logic        jr_is_return;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        ras_mismatch;
  logic        ras_underflow;
  logic        ras_empty;

  int n_vec = 0;
  int n_err = 0;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .jump_valid    (jump_valid),
    .jump_link     (jump_link),
    .jump_field    (jump_field),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jr_valid      (jr_valid),
    .jr_is_return  (jr_is_return),
    .jr_target     (jr_target),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .redirect      (redirect),
    .ras_mismatch  (ras_mismatch),
    .ras_underflow (ras_underflow),
    .ras_empty     (ras_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle;
    stall        = 1'b0;
    jump_valid   = 1'b0;
    jump_link    = 1'b0;
    jump_field   = '0;
    branch_taken = 1'b0;
    branch_offset = '0;
    jr_valid     = 1'b0;
    jr_is_return = 1'b0;
    jr_target    = '0;
  endtask

  task automatic do_jr(input logic [31:0] t, input logic ret);
    idle();
    jr_valid     = 1'b1;
    jr_is_return = ret;
    jr_target    = t;
    step();
    idle();
  endtask

  task automatic do_jal(input logic [25:0] f);
    idle();
    jump_valid = 1'b1;
    jump_link  = 1'b1;
    jump_field = f;
    step();
    idle();
  endtask

  logic [31:0] ret_tgt [5];
  logic [25:0] jal_fld [5];

  initial begin
    ret_tgt[0] = 32'h9000_0104;
    ret_tgt[1] = 32'h9000_00C4;
    ret_tgt[2] = 32'h9000_0084;
    ret_tgt[3] = 32'h9000_0044;
    ret_tgt[4] = 32'h9000_0008;
    jal_fld[0] = 26'h10;
    jal_fld[1] = 26'h20;
    jal_fld[2] = 26'h30;
    jal_fld[3] = 26'h40;
    jal_fld[4] = 26'h50;

    idle();
    reset = 1'b1;
    @(negedge clk);
    step();
    reset = 1'b0;
    chk("rst_pc", pc, 32'h0);
    chk("rst_redirect", 32'(redirect), 32'h0);
    chk("rst_mismatch", 32'(ras_mismatch), 32'h0);
    chk("rst_underflow", 32'(ras_underflow), 32'h0);
    chk("rst_empty", 32'(ras_empty), 32'h1);
    chk("rst_plus4", pc_plus4, 32'h4);

    for (int i = 1; i <= 3; i++) begin
      step();
      chk("seq_pc", pc, 32'(4 * i));
      chk("seq_redirect", 32'(redirect), 32'h0);
    end

    do_jr(32'h0040_0010, 1'b0);
    chk("jr_pc", pc, 32'h0040_0010);
    chk("jr_redirect", 32'(redirect), 32'h1);
    branch_taken  = 1'b1;
    branch_offset = 16'hFFFE;
    step();
    idle();
    chk("br_back_pc", pc, 32'h0040_000C);
    chk("br_redirect", 32'(redirect), 32'h1);
    step();
    chk("br_after_pc", pc, 32'h0040_0010);
    chk("br_after_redirect", 32'(redirect), 32'h0);

    do_jr(32'h9000_0000, 1'b0);
    do_jal(26'h0000100);
    chk("jal_pc", pc, 32'h9000_0400);
    chk("jal_not_empty", 32'(ras_empty), 32'h0);
    do_jr(32'h9000_0004, 1'b1);
    chk("ret_pc", pc, 32'h9000_0004);
    chk("ret_mismatch", 32'(ras_mismatch), 32'h0);
    chk("ret_underflow", 32'(ras_underflow), 32'h0);
    chk("ret_empty", 32'(ras_empty), 32'h1);

    for (int i = 0; i < 5; i++) begin
      do_jal(jal_fld[i]);
      chk("jal5_pc", pc, 32'h9000_0000 | (32'(jal_fld[i]) << 2));
    end
    for (int i = 0; i < 4; i++) begin
      do_jr(ret_tgt[i], 1'b1);
      chk("ret4_pc", pc, ret_tgt[i]);
      chk("ret4_mismatch", 32'(ras_mismatch), 32'h0);
      chk("ret4_underflow", 32'(ras_underflow), 32'h0);
    end
    chk("ret4_empty", 32'(ras_empty), 32'h1);
    do_jr(ret_tgt[4], 1'b1);
    chk("ret5_pc", pc, 32'h9000_0008);
    chk("ret5_underflow", 32'(ras_underflow), 32'h1);
    chk("ret5_mismatch", 32'(ras_mismatch), 32'h0);

    do_jal(26'h200);
    chk("bad_jal_pc", pc, 32'h9000_0800);
    do_jr(32'h9000_0010, 1'b1);
    chk("bad_ret_pc", pc, 32'h9000_0010);
    chk("bad_ret_mismatch", 32'(ras_mismatch), 32'h1);
    chk("bad_ret_empty", 32'(ras_empty), 32'h1);

    do_jal(26'h300);
    chk("prio_jal_pc", pc, 32'h9000_0C00);
    jr_valid     = 1'b1;
    jr_target    = 32'h1234_567B;
    branch_taken = 1'b1;
    branch_offset = 16'h0010;
    jump_valid   = 1'b1;
    jump_link    = 1'b1;
    jump_field   = 26'h3FF;
    step();
    idle();
    chk("prio_pc", pc, 32'h1234_5678);
    chk("prio_redirect", 32'(redirect), 32'h1);
    chk("prio_not_empty", 32'(ras_empty), 32'h0);
    do_jr(32'h9000_0014, 1'b1);
    chk("prio_ret_mismatch", 32'(ras_mismatch), 32'h0);
    chk("prio_ret_empty", 32'(ras_empty), 32'h1);

    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_offset = 16'h0004;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_pc", pc, 32'h9000_0014);
      chk("stall_redirect", 32'(redirect), 32'h0);
    end
    stall = 1'b0;
    step();
    chk("unstall_pc", pc, 32'h9000_0028);
    chk("unstall_redirect", 32'(redirect), 32'h1);
    stall = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    chk("stall_rst_pc", pc, 32'h0);
    chk("stall_rst_redirect", 32'(redirect), 32'h0);

    do_jr(32'hFFFF_FFFF, 1'b0);
    chk("wrap_pre_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    step();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_redirect", 32'(redirect), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
